// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter shared definitions: order codes, master ids, FSM states.
// Used by mem_bus_arbiter and mem_arb_tag_fifo.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] MEM_ARB_ORDER_BYTE = 2'b00;
  localparam logic [1:0] MEM_ARB_ORDER_HALF = 2'b01;
  localparam logic [1:0] MEM_ARB_ORDER_WORD = 2'b10;
  localparam logic [1:0] MEM_ARB_ORDER_NONE = 2'b11;

  localparam logic MEM_ARB_M_FETCH = 1'b0;
  localparam logic MEM_ARB_M_LDST  = 1'b1;

  typedef enum logic {
    MEM_ARB_IDLE = 1'b0,
    MEM_ARB_HOLD = 1'b1
  } mem_arb_state_e;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// mem_arb_tag_fifo: 1-bit in-order owner FIFO for outstanding reads.
// Pointers wrap modulo DEPTH; full/empty derive from the registered count.
module mem_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        din,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wr;
  logic             rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rptr];

  // Tag storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  // Pointers and occupancy; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      if (wr && !rd) count <= count + (AW+1)'(1);
      else if (rd && !wr) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master memory bus arbiter with in-order read tags.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; default is M1-over-M0 priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int PL_TAG_DEPTH = 8,
  parameter int PL_TAG_AW    = 3
) (
  input  logic        iCLOCK,
  input  logic        iRESET,
  input  logic        iM0_REQ,
  output logic        oM0_BUSY,
  input  logic [1:0]  iM0_ORDER,
  input  logic [3:0]  iM0_MASK,
  input  logic        iM0_RW,
  input  logic [31:0] iM0_ADDR,
  input  logic [31:0] iM0_DATA,
  output logic        oM0_VALID,
  input  logic        iM0_BUSY,
  output logic [63:0] oM0_DATA,
  input  logic        iM1_REQ,
  output logic        oM1_BUSY,
  input  logic [1:0]  iM1_ORDER,
  input  logic [3:0]  iM1_MASK,
  input  logic        iM1_RW,
  input  logic [31:0] iM1_ADDR,
  input  logic [31:0] iM1_DATA,
  output logic        oM1_VALID,
  input  logic        iM1_BUSY,
  output logic [63:0] oM1_DATA,
  output logic        oMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [31:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_VALID,
  output logic        oMEMORY_BUSY,
  input  logic [63:0] iMEMORY_DATA,
  output logic        oARB_ERROR
);

  mem_arb_state_e state;
  logic           owner;
  logic           pick;
  logic           sel;
  logic           sel_valid;
  logic [1:0]     elig;
  logic           accept;
  logic           push;
  logic           pop;
  logic           head;
  logic           tag_full;
  logic           tag_empty;
  logic [PL_TAG_AW:0] tag_count;
  logic           unused_count;

  // Count is kept on the FIFO for observability only.
  assign unused_count = ^tag_count;

  assign elig[0] = !iRESET && iM0_REQ && (iM0_RW || !tag_full);
  assign elig[1] = !iRESET && iM1_REQ && (iM1_RW || !tag_full);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr;

  assign pick = rr;

  // Priority flips to the master that lost each accepted cycle.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) rr <= MEM_ARB_M_FETCH;
    else if (accept) rr <= !sel;
  end
`else
  assign pick = MEM_ARB_M_LDST;
`endif

  // Owner selection: HOLD sticks to the latched owner, IDLE arbitrates.
  always_comb begin
    sel       = MEM_ARB_M_FETCH;
    sel_valid = 1'b0;
    if (state == MEM_ARB_HOLD) begin
      sel       = owner;
      sel_valid = elig[owner];
    end else begin
      sel_valid = |elig;
      sel       = (&elig) ? pick : elig[1];
    end
  end

  // Drive the selected master's fields; zeros when nobody is selected.
  always_comb begin
    oMEMORY_REQ   = sel_valid;
    oMEMORY_ORDER = '0;
    oMEMORY_MASK  = '0;
    oMEMORY_RW    = 1'b0;
    oMEMORY_ADDR  = '0;
    oMEMORY_DATA  = '0;
    if (sel_valid) begin
      if (sel == MEM_ARB_M_LDST) begin
        oMEMORY_ORDER = iM1_ORDER;
        oMEMORY_MASK  = iM1_MASK;
        oMEMORY_RW    = iM1_RW;
        oMEMORY_ADDR  = iM1_ADDR;
        oMEMORY_DATA  = iM1_DATA;
      end else begin
        oMEMORY_ORDER = iM0_ORDER;
        oMEMORY_MASK  = iM0_MASK;
        oMEMORY_RW    = iM0_RW;
        oMEMORY_ADDR  = iM0_ADDR;
        oMEMORY_DATA  = iM0_DATA;
      end
    end
  end

  assign accept   = sel_valid && !iMEMORY_LOCK;
  assign oM0_BUSY = !(accept && sel == MEM_ARB_M_FETCH);
  assign oM1_BUSY = !(accept && sel == MEM_ARB_M_LDST);
  assign push     = accept && !oMEMORY_RW;

  assign oM0_VALID    = iMEMORY_VALID && !tag_empty && !head;
  assign oM1_VALID    = iMEMORY_VALID && !tag_empty && head;
  assign oM0_DATA     = iRESET ? '0 : iMEMORY_DATA;
  assign oM1_DATA     = iRESET ? '0 : iMEMORY_DATA;
  assign oMEMORY_BUSY = !tag_empty && (head ? iM1_BUSY : iM0_BUSY);
  assign pop          = iMEMORY_VALID && !oMEMORY_BUSY && !tag_empty;

  // Lock hold: latch the owner while memory stalls, release on accept or drop.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state <= MEM_ARB_IDLE;
      owner <= MEM_ARB_M_FETCH;
    end else begin
      unique case (state)
        MEM_ARB_IDLE: begin
          if (sel_valid && iMEMORY_LOCK) begin
            state <= MEM_ARB_HOLD;
            owner <= sel;
          end
        end
        MEM_ARB_HOLD: begin
          if (!sel_valid || !iMEMORY_LOCK) state <= MEM_ARB_IDLE;
        end
      endcase
    end
  end

  // A return with no outstanding tag is unroutable; flag it until reset.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) oARB_ERROR <= 1'b0;
    else if (iMEMORY_VALID && tag_empty) oARB_ERROR <= 1'b1;
  end

  mem_arb_tag_fifo #(
    .DEPTH (PL_TAG_DEPTH),
    .AW    (PL_TAG_AW)
  ) u_tag_fifo (
    .clk   (iCLOCK),
    .rst   (iRESET),
    .push  (push),
    .pop   (pop),
    .din   (sel),
    .dout  (head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

endmodule
